// File: rtl/iob_fifo_stream_reader_pkg.sv
// Purpose: shared defaults, FSM state encoding and output-buffer sizing for iob_fifo_stream_reader.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: none; the credit helper below is what keeps the output buffer from overflowing.
package iob_fifo_stream_reader_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int LEN_W_DEF     = 16;
  localparam int TIMEOUT_W_DEF = 8;

  // Output buffer depth and the width of its occupancy count (0..BUF_DEPTH).
  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A new read may be issued only if the word it returns is guaranteed a slot:
  // occ + inflight - pop < BUF_DEPTH, rearranged to avoid a signed subtraction.
  function automatic logic credit_ok(input logic [OCC_W-1:0] occ,
                                     input logic             inflight,
                                     input logic             pop);
    return ({1'b0, occ} + {2'b00, inflight}) < (3'(BUF_DEPTH) + {2'b00, pop});
  endfunction

endpackage

// File: rtl/iob_fifo_stream_reader_skid.sv
// Purpose: 2-entry registered output buffer (data + last) feeding the stream port.
// Latency: a pushed word is visible on data_o/last_o the cycle after the push edge.
// Backpressure: none internally; the caller must never push into a full buffer without a pop.
//
// Ports: clk_i/arst_n_i/cke_i/rst_i  clock, async reset, clock enable, sync clear
//        flush_i                      drop all buffered words
//        push_i/push_data_i/push_last_i  write one word
//        pop_i                        consume the head word
//        occ_o                        number of buffered words (0..2)
//        data_o/last_o                head word, registered
module iob_fifo_stream_reader_skid
  import iob_fifo_stream_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  input  logic              pop_i,
  output logic [OCC_W-1:0]  occ_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

  // Second slot; the head slot is data_o/last_o itself so the outputs come straight from flops.
  logic [DATA_W-1:0] data1;
  logic              last1;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      occ_o  <= '0;
      data_o <= '0;
      last_o <= 1'b0;
      data1  <= '0;
      last1  <= 1'b0;
    end else if (cke_i) begin
      if (rst_i || flush_i) begin
        occ_o  <= '0;
        data_o <= '0;
        last_o <= 1'b0;
        data1  <= '0;
        last1  <= 1'b0;
      end else begin
        if (push_i && !pop_i) begin
          assert (occ_o != OCC_FULL);
        end
        case ({push_i, pop_i})
          2'b10: begin
            if (occ_o == '0) begin
              data_o <= push_data_i;
              last_o <= push_last_i;
            end else begin
              data1 <= push_data_i;
              last1 <= push_last_i;
            end
            occ_o <= occ_o + OCC_ONE;
          end
          2'b01: begin
            data_o <= data1;
            last_o <= last1;
            occ_o  <= occ_o - OCC_ONE;
          end
          2'b11: begin
            // Occupancy unchanged: the new word either replaces the head or queues behind slot 1.
            if (occ_o == OCC_ONE) begin
              data_o <= push_data_i;
              last_o <= push_last_i;
            end else begin
              data_o <= data1;
              last_o <= last1;
              data1  <= push_data_i;
              last1  <= push_last_i;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/iob_fifo_stream_reader.sv
// Purpose: pops a len_i-word frame from a 1-cycle-latency FIFO read port and streams it out with tlast.
// Latency: start_i cycle 0 -> fifo_r_en_o cycle 1 -> m_tvalid_o cycle 3; 1 word/cycle sustained.
// Backpressure: m_tready_i low fills the 2-word buffer, then FIFO reads stop until a pop frees a credit.
//
// Ports: clk_i/arst_n_i/cke_i/rst_i  clock, async reset, clock enable, sync clear (aborts a frame)
//        start_i/len_i               frame start pulse and length, sampled in IDLE
//        pause_i                     hold off new FIFO reads
//        fifo_r_en_o/fifo_r_data_i/fifo_r_empty_i  FIFO read port
//        m_tvalid_o/m_tready_i/m_tdata_o/m_tlast_o  output stream
//        busy_o/done_o               frame in progress / end-of-frame pulse
// Optional: define IOB_FIFO_STREAM_READER_TIMEOUT_EN to add the stall watchdog
//        (parameter TIMEOUT_W, output timeout_o).
module iob_fifo_stream_reader
  import iob_fifo_stream_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
`ifdef IOB_FIFO_STREAM_READER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
`endif
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              pause_i,
  output logic              fifo_r_en_o,
  input  logic [DATA_W-1:0] fifo_r_data_i,
  input  logic              fifo_r_empty_i,
  output logic              m_tvalid_o,
  input  logic              m_tready_i,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic              m_tlast_o,
  output logic              busy_o,
  output logic              done_o
`ifdef IOB_FIFO_STREAM_READER_TIMEOUT_EN
  ,
  output logic              timeout_o
`endif
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] sent;
  logic             inflight;       // a read was issued last cycle; its data is on fifo_r_data_i now
  logic             inflight_last;  // ...and that word is the last of the frame
  logic [OCC_W-1:0] occ;
  logic             buf_last;
  logic             pop;
  logic             flush;

  assign m_tvalid_o  = (occ != '0);
  assign pop         = m_tvalid_o & m_tready_i;
  // Stale last bits may linger in an empty buffer slot; only present tlast with a valid word.
  assign m_tlast_o   = buf_last & m_tvalid_o;
  assign fifo_r_en_o = (state == ST_RUN) & ~pause_i & ~fifo_r_empty_i &
                       (issued < len_q) & credit_ok(occ, inflight, pop);

`ifdef IOB_FIFO_STREAM_READER_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] WDOG_ONE = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] wdog;
  logic                 wdog_fire;

  // Fires on an idle cycle once the idle count has saturated; no read is in flight at that point.
  assign wdog_fire = (state != ST_IDLE) & ~pop & ~fifo_r_en_o & (wdog == WDOG_MAX);
  assign flush     = wdog_fire;
`else
  assign flush = 1'b0;
`endif

  iob_fifo_stream_reader_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .cke_i       (cke_i),
    .rst_i       (rst_i),
    .flush_i     (flush),
    .push_i      (inflight),
    .push_data_i (fifo_r_data_i),
    .push_last_i (inflight_last),
    .pop_i       (pop),
    .occ_o       (occ),
    .data_o      (m_tdata_o),
    .last_o      (buf_last)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      issued        <= '0;
      sent          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
`ifdef IOB_FIFO_STREAM_READER_TIMEOUT_EN
      wdog          <= '0;
      timeout_o     <= 1'b0;
`endif
    end else if (cke_i) begin
      if (rst_i) begin
        // Abort: in-flight data is dropped by clearing inflight; the buffer clears itself.
        state         <= ST_IDLE;
        len_q         <= '0;
        issued        <= '0;
        sent          <= '0;
        inflight      <= 1'b0;
        inflight_last <= 1'b0;
        busy_o        <= 1'b0;
        done_o        <= 1'b0;
`ifdef IOB_FIFO_STREAM_READER_TIMEOUT_EN
        wdog          <= '0;
        timeout_o     <= 1'b0;
`endif
      end else begin
        done_o        <= 1'b0;
        inflight      <= fifo_r_en_o;
        // The last flag is decided at issue time, when the word's index is known.
        inflight_last <= fifo_r_en_o & (issued == len_q - LEN_ONE);
        if (fifo_r_en_o) begin
          issued <= issued + LEN_ONE;
        end
        if (pop) begin
          assert (m_tlast_o == (sent == len_q - LEN_ONE));
          sent <= sent + LEN_ONE;
        end

        case (state)
          ST_IDLE: begin
            if (start_i) begin
              if (len_i != '0) begin
                len_q  <= len_i;
                issued <= '0;
                sent   <= '0;
                state  <= ST_RUN;
                busy_o <= 1'b1;
              end else begin
                done_o <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (issued == len_q) begin
              state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (pop && m_tlast_o) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase

`ifdef IOB_FIFO_STREAM_READER_TIMEOUT_EN
        timeout_o <= 1'b0;
        if (state == ST_IDLE || pop || fifo_r_en_o) begin
          wdog <= '0;
        end else if (wdog_fire) begin
          state     <= ST_IDLE;
          busy_o    <= 1'b0;
          done_o    <= 1'b1;
          timeout_o <= 1'b1;
          wdog      <= '0;
        end else begin
          wdog <= wdog + WDOG_ONE;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_iob_fifo_stream_reader.sv
// Purpose: directed + randomized bench for iob_fifo_stream_reader against a frame-level reference model.
// Latency: checks first beat 3 cycles after start and done one cycle after the final beat.
// Backpressure: drives constant, patterned and random tready plus random pause.
module tb_iob_fifo_stream_reader;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk_i = 1'b0;
  logic              arst_n_i;
  logic              cke_i;
  logic              rst_i;
  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic              pause_i;
  logic              fifo_r_en_o;
  logic [DATA_W-1:0] fifo_r_data_i;
  logic              fifo_r_empty_i;
  logic              m_tvalid_o;
  logic              m_tready_i;
  logic [DATA_W-1:0] m_tdata_o;
  logic              m_tlast_o;
  logic              busy_o;
  logic              done_o;

  iob_fifo_stream_reader #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk_i          (clk_i),
    .arst_n_i       (arst_n_i),
    .cke_i          (cke_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .len_i          (len_i),
    .pause_i        (pause_i),
    .fifo_r_en_o    (fifo_r_en_o),
    .fifo_r_data_i  (fifo_r_data_i),
    .fifo_r_empty_i (fifo_r_empty_i),
    .m_tvalid_o     (m_tvalid_o),
    .m_tready_i     (m_tready_i),
    .m_tdata_o      (m_tdata_o),
    .m_tlast_o      (m_tlast_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents, words read but not yet streamed, and frame bookkeeping.
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] owed_q[$];
  bit                active = 0;
  bit                busy_exp = 0;
  bit                done_exp = 0;
  bit                prev_hold = 0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;
  int len_m = 0, beat_idx = 0, reads_m = 0, outstanding = 0;
  int cyc = 0, start_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0;
  int rdy_mode = 0, rdy_cnt = 0, pause_pct = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check settled outputs, advance the model at the edge.
  task automatic cycle(input int st, input int ln, input int rs);
    logic              rd;
    logic              pop;
    bit                fin;
    int                pop_n;
    logic [DATA_W-1:0] rd_word;
    rd_word = '0;
    fin     = 0;
    @(negedge clk_i);
    start_i = (st != 0);
    len_i   = LEN_W'(ln);
    rst_i   = (rs != 0);
    pause_i = (pause_pct > 0) && ($urandom_range(99) < 32'(pause_pct));
    case (rdy_mode)
      0:       m_tready_i = 1'b1;
      1:       m_tready_i = ((rdy_cnt % 3) == 0);
      default: m_tready_i = 1'($urandom_range(1));
    endcase
    if (rs != 0) m_tready_i = 1'b0;
    rdy_cnt++;
    fifo_r_empty_i = (fifo_q.size() == 0);
    #1;
    chk("busy", 32'(busy_o), 32'(busy_exp));
    chk("done", 32'(done_o), 32'(done_exp));
    if (prev_hold) begin
      chk("hold_vld", 32'(m_tvalid_o), 32'd1);
      chk("hold_dat", m_tdata_o, prev_data);
      chk("hold_last", 32'(m_tlast_o), 32'(prev_last));
    end
    rd    = fifo_r_en_o;
    pop   = m_tvalid_o & m_tready_i;
    pop_n = pop ? 1 : 0;
    if (rd) begin
      chk("rd_in_frame", 32'(active), 32'd1);
      chk("rd_not_empty", 32'(fifo_r_empty_i), 32'd0);
      chk("rd_not_paused", 32'(pause_i), 32'd0);
      chk("rd_count", 32'(reads_m < len_m), 32'd1);
      chk("rd_credit", 32'(outstanding - pop_n < 2), 32'd1);
      if (fifo_q.size() > 0) begin
        rd_word = fifo_q.pop_front();
        owed_q.push_back(rd_word);
      end
      reads_m++;
    end
    if (pop) begin
      chk("beat_in_frame", 32'(active), 32'd1);
      chk("beat_owed", 32'(owed_q.size() > 0), 32'd1);
      if (owed_q.size() > 0) chk("tdata", m_tdata_o, owed_q.pop_front());
      chk("tlast", 32'(m_tlast_o), 32'(beat_idx == len_m - 1));
      if (beat_idx == 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      beat_idx++;
      if (beat_idx == len_m) fin = 1;
    end
    outstanding = outstanding + (rd ? 1 : 0) - pop_n;
    prev_hold   = m_tvalid_o & ~m_tready_i;
    prev_data   = m_tdata_o;
    prev_last   = m_tlast_o;

    done_exp = 0;
    if (rs != 0) begin
      active = 0;
      owed_q.delete();
      outstanding = 0;
      prev_hold = 0;
    end else if (fin) begin
      chk("frame_reads", 32'(reads_m), 32'(len_m));
      active   = 0;
      done_exp = 1;
    end else if (!active && st != 0) begin
      if (ln == 0) begin
        done_exp = 1;
      end else begin
        active    = 1;
        len_m     = ln;
        beat_idx  = 0;
        reads_m   = 0;
        start_cyc = cyc;
      end
    end
    busy_exp = active;

    @(posedge clk_i);
    #1;
    fifo_r_data_i = rd ? rd_word : $urandom();
    cyc++;
  endtask

  task automatic run_frame(input int budget);
    int i;
    i = 0;
    while (active && i < budget) begin
      cycle(0, 0, 0);
      i++;
    end
    chk("frame_completes", 32'(active), 32'd0);
    cycle(0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "bench time limit");
  end

  initial begin
    int i;
    arst_n_i = 1'b0; cke_i = 1'b1; rst_i = 1'b0; start_i = 1'b0; len_i = '0;
    pause_i = 1'b0; m_tready_i = 1'b0; fifo_r_empty_i = 1'b1; fifo_r_data_i = '0;
    #12;
    chk("rst_tvalid", 32'(m_tvalid_o), 32'd0);
    chk("rst_tlast", 32'(m_tlast_o), 32'd0);
    chk("rst_r_en", 32'(fifo_r_en_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_tdata", m_tdata_o, 32'd0);
    @(negedge clk_i);
    arst_n_i = 1'b1;
    cycle(0, 0, 0);

    // Preloaded 0x10..0x17, full-rate stream.
    for (int k = 0; k < 8; k++) fifo_q.push_back(DATA_W'(32'h10 + k));
    cycle(1, 8, 0);
    run_frame(100);
    chk("t1_first_latency", 32'(first_beat_cyc - start_cyc), 32'd3);
    chk("t1_beat_span", 32'(last_beat_cyc - first_beat_cyc), 32'd7);

    // Patterned backpressure.
    rdy_mode = 1; rdy_cnt = 0;
    for (int k = 0; k < 4; k++) fifo_q.push_back($urandom());
    cycle(1, 4, 0);
    run_frame(100);
    rdy_mode = 0;

    // FIFO runs dry mid-frame, refilled 10 cycles later.
    for (int k = 0; k < 2; k++) fifo_q.push_back($urandom());
    cycle(1, 6, 0);
    repeat (10) cycle(0, 0, 0);
    chk("t3_stall_busy", 32'(busy_o), 32'd1);
    chk("t3_stall_tvalid", 32'(m_tvalid_o), 32'd0);
    chk("t3_stall_beats", 32'(beat_idx), 32'd2);
    for (int k = 0; k < 4; k++) fifo_q.push_back($urandom());
    run_frame(100);

    // Synchronous abort after 3 beats, then a short frame.
    for (int k = 0; k < 8; k++) fifo_q.push_back($urandom());
    cycle(1, 8, 0);
    i = 0;
    while (beat_idx < 3 && i < 50) begin
      cycle(0, 0, 0);
      i++;
    end
    chk("t4_beats_before_abort", 32'(beat_idx), 32'd3);
    cycle(0, 0, 1);
    chk("t4_abort_tvalid", 32'(m_tvalid_o), 32'd0);
    chk("t4_abort_busy", 32'(busy_o), 32'd0);
    cycle(0, 0, 0);
    for (int k = 0; k < 2; k++) fifo_q.push_back($urandom());
    cycle(1, 2, 0);
    run_frame(50);

    // Zero-length frame with words available in the FIFO.
    for (int k = 0; k < 3; k++) fifo_q.push_back($urandom());
    cycle(1, 0, 0);
    chk("t5_r_en", 32'(fifo_r_en_o), 32'd0);
    chk("t5_tvalid", 32'(m_tvalid_o), 32'd0);
    cycle(0, 0, 0);
    chk("t5_r_en_after", 32'(fifo_r_en_o), 32'd0);
    cycle(0, 0, 0);

    // Random frames: random length, tready, pause and late FIFO refill.
    rdy_mode = 2; pause_pct = 25;
    for (int f = 0; f < 6; f++) begin
      int ln;
      int now_n;
      ln    = int'($urandom_range(12, 1));
      now_n = int'($urandom_range(ln, 0));
      for (int k = 0; k < now_n; k++) fifo_q.push_back($urandom());
      cycle(1, ln, 0);
      repeat ($urandom_range(6, 0)) cycle(0, 0, 0);
      for (int k = now_n; k < ln; k++) fifo_q.push_back($urandom());
      run_frame(400);
    end
    rdy_mode = 0; pause_pct = 0;
    cycle(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
